// File: rtl/rf_op_sequencer.sv
// Micro-operation sequencer wrapped around an 8-entry register file:
// reads the operands, runs an ALU op or an iterative shift-add multiply, and writes the result back.
module rf_op_sequencer #(
  parameter int unsigned W = 4
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         Op_Valid,
  output logic         Op_Ready,
  input  logic [2:0]   Op_Code,
  input  logic [2:0]   Op_Dest,
  input  logic [2:0]   Op_Src0,
  input  logic [2:0]   Op_Src1,
  input  logic [W-1:0] Op_Imm,
  output logic [W-1:0] RF_Data,
  output logic [2:0]   RF_Destination_Select,
  output logic         RF_Write_Enable,
  output logic [2:0]   RF_Source_Select_0,
  output logic [2:0]   RF_Source_Select_1,
  input  logic [W-1:0] RF_Out_0,
  input  logic [W-1:0] RF_Out_1,
  output logic         Done,
  output logic         Carry,
  output logic         Zero
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_MULT  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_AND   = 3'd2;
  localparam logic [2:0] OP_OR    = 3'd3;
  localparam logic [2:0] OP_XOR   = 3'd4;
  localparam logic [2:0] OP_LOADI = 3'd5;
  localparam logic [2:0] OP_MUL   = 3'd6;
  localparam logic [2:0] OP_NOP   = 3'd7;

  localparam logic [W-1:0] MUL_LAST = W'(W - 1);

  logic [2:0]   state_q,    state_nxt;
  logic [2:0]   op_q,       op_nxt;
  logic [2:0]   dest_q,     dest_nxt;
  logic [W-1:0] a_q,        a_nxt;
  logic [W-1:0] b_q,        b_nxt;
  logic [W-1:0] acc_q,      acc_nxt;
  logic [W-1:0] cnt_q,      cnt_nxt;
  logic [W-1:0] rf_data_q,  rf_data_nxt;
  logic [2:0]   dsel_q,     dsel_nxt;
  logic [2:0]   sel0_q,     sel0_nxt;
  logic [2:0]   sel1_q,     sel1_nxt;
  logic         we_q,       we_nxt;
  logic         done_q,     done_nxt;
  logic         ready_q,    ready_nxt;
  logic         carry_q,    carry_nxt;
  logic         zero_q,     zero_nxt;
  logic         wcarry_q,   wcarry_nxt;

  logic [W:0]   sum;
  logic [W:0]   diff;
  logic [W-1:0] acc_step;
  logic [W-1:0] alu_res;
  logic         alu_cy;

  // Single-cycle ALU and one shift-add step of the multiplier
  always_comb begin
    sum      = {1'b0, a_q} + {1'b0, b_q};
    diff     = {1'b0, a_q} - {1'b0, b_q};
    acc_step = acc_q + (b_q[0] ? a_q : '0);
    alu_res  = '0;
    alu_cy   = 1'b0;
    case (op_q)
      OP_ADD: begin alu_res = sum[W-1:0];  alu_cy = sum[W];  end
      OP_SUB: begin alu_res = diff[W-1:0]; alu_cy = diff[W]; end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      default: alu_res = '0;
    endcase
  end

  // Next-state and next-output logic; outputs are loaded on the edge that enters their state
  always_comb begin
    state_nxt   = state_q;
    op_nxt      = op_q;
    dest_nxt    = dest_q;
    a_nxt       = a_q;
    b_nxt       = b_q;
    acc_nxt     = acc_q;
    cnt_nxt     = cnt_q;
    dsel_nxt    = dsel_q;
    sel0_nxt    = sel0_q;
    sel1_nxt    = sel1_q;
    carry_nxt   = carry_q;
    zero_nxt    = zero_q;
    wcarry_nxt  = wcarry_q;
    rf_data_nxt = '0;
    we_nxt      = 1'b0;
    done_nxt    = 1'b0;
    ready_nxt   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Op_Valid && ready_q) begin
          op_nxt   = Op_Code;
          dest_nxt = Op_Dest;
          if (Op_Code == OP_LOADI || Op_Code == OP_NOP) begin
            state_nxt   = S_WRITE;
            rf_data_nxt = (Op_Code == OP_LOADI) ? Op_Imm : '0;
            wcarry_nxt  = 1'b0;
            dsel_nxt    = Op_Dest;
            we_nxt      = (Op_Code != OP_NOP);
            done_nxt    = 1'b1;
          end else begin
            state_nxt = S_READ;
            sel0_nxt  = Op_Src0;
            sel1_nxt  = Op_Src1;
          end
        end else begin
          ready_nxt = 1'b1;
        end
      end
      S_READ: begin
        a_nxt     = RF_Out_0;
        b_nxt     = RF_Out_1;
        acc_nxt   = '0;
        cnt_nxt   = '0;
        state_nxt = (op_q == OP_MUL) ? S_MULT : S_EXEC;
      end
      S_EXEC: begin
        state_nxt   = S_WRITE;
        rf_data_nxt = alu_res;
        wcarry_nxt  = alu_cy;
        dsel_nxt    = dest_q;
        we_nxt      = 1'b1;
        done_nxt    = 1'b1;
      end
      S_MULT: begin
        acc_nxt = acc_step;
        a_nxt   = a_q << 1;
        b_nxt   = b_q >> 1;
        cnt_nxt = cnt_q + W'(1);
        if (cnt_q == MUL_LAST) begin
          state_nxt   = S_WRITE;
          rf_data_nxt = acc_step;
          wcarry_nxt  = 1'b0;
          dsel_nxt    = dest_q;
          we_nxt      = 1'b1;
          done_nxt    = 1'b1;
        end
      end
      S_WRITE: begin
        state_nxt = S_IDLE;
        ready_nxt = 1'b1;
        if (op_q != OP_NOP) begin
          carry_nxt = wcarry_q;
          zero_nxt  = (rf_data_q == '0);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        ready_nxt = 1'b1;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      dest_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      rf_data_q <= '0;
      dsel_q    <= '0;
      sel0_q    <= '0;
      sel1_q    <= '0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      wcarry_q  <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      op_q      <= op_nxt;
      dest_q    <= dest_nxt;
      a_q       <= a_nxt;
      b_q       <= b_nxt;
      acc_q     <= acc_nxt;
      cnt_q     <= cnt_nxt;
      rf_data_q <= rf_data_nxt;
      dsel_q    <= dsel_nxt;
      sel0_q    <= sel0_nxt;
      sel1_q    <= sel1_nxt;
      we_q      <= we_nxt;
      done_q    <= done_nxt;
      ready_q   <= ready_nxt;
      carry_q   <= carry_nxt;
      zero_q    <= zero_nxt;
      wcarry_q  <= wcarry_nxt;
    end
  end

  // Reset discards an op caught in WRITE: no write strobe and no retire pulse
  assign RF_Write_Enable       = we_q & ~Reset;
  assign Done                  = done_q & ~Reset;
  assign Op_Ready              = ready_q;
  assign RF_Data               = rf_data_q;
  assign RF_Destination_Select = dsel_q;
  assign RF_Source_Select_0    = sel0_q;
  assign RF_Source_Select_1    = sel1_q;
  assign Carry                 = carry_q;
  assign Zero                  = zero_q;

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Randomised bench for rf_op_sequencer: attached register file plus an arithmetic reference model
// that predicts results, flags and retire latency for every operation.
module tb_rf_op_sequencer;
  localparam int unsigned W = 4;
  localparam int MOD = 1 << W;

  logic         CLK = 1'b0;
  logic         Reset;
  logic         Op_Valid;
  logic         Op_Ready;
  logic [2:0]   Op_Code, Op_Dest, Op_Src0, Op_Src1;
  logic [W-1:0] Op_Imm;
  logic [W-1:0] RF_Data;
  logic [2:0]   RF_Destination_Select;
  logic         RF_Write_Enable;
  logic [2:0]   RF_Source_Select_0, RF_Source_Select_1;
  logic [W-1:0] RF_Out_0, RF_Out_1;
  logic         Done, Carry, Zero;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] rf [8];
  int ref_rf [8];
  int ref_carry = 0;
  int ref_zero  = 0;

  rf_op_sequencer #(.W(W)) dut (
    .CLK(CLK), .Reset(Reset), .Op_Valid(Op_Valid), .Op_Ready(Op_Ready),
    .Op_Code(Op_Code), .Op_Dest(Op_Dest), .Op_Src0(Op_Src0), .Op_Src1(Op_Src1),
    .Op_Imm(Op_Imm), .RF_Data(RF_Data), .RF_Destination_Select(RF_Destination_Select),
    .RF_Write_Enable(RF_Write_Enable), .RF_Source_Select_0(RF_Source_Select_0),
    .RF_Source_Select_1(RF_Source_Select_1), .RF_Out_0(RF_Out_0), .RF_Out_1(RF_Out_1),
    .Done(Done), .Carry(Carry), .Zero(Zero)
  );

  always #5 CLK = ~CLK;

  // Attached register file: combinational read, write on the rising edge
  assign RF_Out_0 = rf[RF_Source_Select_0];
  assign RF_Out_1 = rf[RF_Source_Select_1];
  always @(posedge CLK) if (RF_Write_Enable) rf[RF_Destination_Select] <= RF_Data;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model(input int code, input int a, input int b, input int imm,
                                output int res, output int cy);
    cy = 0;
    case (code)
      0: begin res = (a + b) % MOD; cy = (a + b >= MOD) ? 1 : 0; end
      1: begin res = (a - b + MOD) % MOD; cy = (a < b) ? 1 : 0; end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = imm % MOD;
      6: res = (a * b) % MOD;
      default: res = 0;
    endcase
  endfunction

  // Called at a falling edge inside an IDLE cycle; returns at the falling edge of the next IDLE cycle
  task automatic do_op(input int code, input int dest, input int s0, input int s1, input int imm);
    int res, cy, lat, exp_lat;
    bit wr, seen;
    model(code, ref_rf[s0], ref_rf[s1], imm, res, cy);
    wr = (code != 7);
    // falling edges from acceptance to the WRITE cycle, inclusive
    exp_lat = (code == 5 || code == 7) ? 1 : (code == 6 ? int'(W) + 2 : 3);
    check("ready_at_issue", int'(Op_Ready), 1);
    Op_Valid = 1'b1;
    Op_Code  = 3'(code);
    Op_Dest  = 3'(dest);
    Op_Src0  = 3'(s0);
    Op_Src1  = 3'(s1);
    Op_Imm   = W'(imm);
    @(negedge CLK);
    lat  = 1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (Done) begin
        seen = 1'b1;
        break;
      end
      check("busy_ready", int'(Op_Ready), 0);
      Op_Valid = 1'($urandom);
      Op_Code  = 3'($urandom);
      Op_Dest  = 3'($urandom);
      Op_Src0  = 3'($urandom);
      Op_Src1  = 3'($urandom);
      Op_Imm   = W'($urandom);
      @(negedge CLK);
      lat++;
    end
    Op_Valid = 1'b0;
    check("done_seen", int'(seen), 1);
    if (!seen) return;
    check("latency", lat, exp_lat);
    check("write_enable", int'(RF_Write_Enable), int'(wr));
    if (wr) begin
      check("rf_data", int'(RF_Data), res);
      check("dest_sel", int'(RF_Destination_Select), dest);
      ref_rf[dest] = res;
      ref_carry    = cy;
      ref_zero     = (res == 0) ? 1 : 0;
    end
    @(negedge CLK);
    check("done_pulse", int'(Done), 0);
    check("carry", int'(Carry), ref_carry);
    check("zero", int'(Zero), ref_zero);
    check("idle_ready", int'(Op_Ready), 1);
  endtask

  task automatic reset_in_mul_write(input int dest, input int s0, input int s1);
    int k;
    check("ready_at_issue", int'(Op_Ready), 1);
    Op_Valid = 1'b1;
    Op_Code  = 3'd6;
    Op_Dest  = 3'(dest);
    Op_Src0  = 3'(s0);
    Op_Src1  = 3'(s1);
    @(negedge CLK);
    Op_Valid = 1'b0;
    k = 1;
    while (k < int'(W) + 2) begin
      @(negedge CLK);
      k++;
    end
    check("mul_in_write_done", int'(Done), 1);
    check("mul_in_write_we", int'(RF_Write_Enable), 1);
    Reset = 1'b1;
    #1;
    check("reset_gates_we", int'(RF_Write_Enable), 0);
    check("reset_gates_done", int'(Done), 0);
    @(negedge CLK);
    Reset = 1'b0;
    ref_carry = 0;
    ref_zero  = 0;
    check("post_reset_ready", int'(Op_Ready), 1);
    check("post_reset_done", int'(Done), 0);
    check("post_reset_carry", int'(Carry), 0);
    check("post_reset_zero", int'(Zero), 0);
    check("post_reset_data", int'(RF_Data), 0);
    check("post_reset_sel0", int'(RF_Source_Select_0), 0);
    check("no_write_on_reset", int'(rf[dest]), ref_rf[dest]);
  endtask

  initial begin
    Reset    = 1'b1;
    Op_Valid = 1'b0;
    Op_Code  = '0;
    Op_Dest  = '0;
    Op_Src0  = '0;
    Op_Src1  = '0;
    Op_Imm   = '0;
    for (int i = 0; i < 8; i++) ref_rf[i] = 0;
    repeat (3) @(negedge CLK);
    Reset = 1'b0;
    check("rst_ready", int'(Op_Ready), 1);
    check("rst_done", int'(Done), 0);
    check("rst_carry", int'(Carry), 0);
    check("rst_zero", int'(Zero), 0);
    check("rst_we", int'(RF_Write_Enable), 0);
    check("rst_data", int'(RF_Data), 0);
    check("rst_dsel", int'(RF_Destination_Select), 0);
    check("rst_sel0", int'(RF_Source_Select_0), 0);
    check("rst_sel1", int'(RF_Source_Select_1), 0);

    // Give every register a known value before it can be read
    for (int r = 0; r < 8; r++) do_op(5, r, 0, 0, int'($urandom_range(0, MOD - 1)));

    do_op(5, 3, 0, 0, 5);
    do_op(5, 4, 0, 0, 11);
    do_op(0, 5, 3, 4, 0);
    do_op(1, 6, 3, 4, 0);
    do_op(1, 6, 4, 3, 0);
    do_op(6, 7, 3, 3, 0);
    do_op(0, 1, 3, 3, 0);
    do_op(4, 2, 1, 3, 0);
    check("r1_value", int'(rf[1]), 10);
    check("r2_value", int'(rf[2]), 15);
    check("r7_value", int'(rf[7]), 9);

    reset_in_mul_write(0, 3, 4);
    do_op(0, 5, 4, 4, 0);
    do_op(7, 6, 1, 2, 0);

    for (int n = 0; n < 150; n++)
      do_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, MOD - 1)));

    for (int r = 0; r < 8; r++) check("final_rf", int'(rf[r]), ref_rf[r]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
